// File: rtl/riscv_pkg.sv
// Shared load-width encodings and the write-back queue entry type.
package riscv_pkg;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword lane of a load word and sign/zero-extends it.
module load_extend
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = data_in[7:0];
    case (offset)
      2'd0: byte_lane = data_in[7:0];
      2'd1: byte_lane = data_in[15:8];
      2'd2: byte_lane = data_in[23:16];
      2'd3: byte_lane = data_in[31:24];
      default: byte_lane = data_in[7:0];
    endcase
    // Halfword lane follows offset[1] only; misaligned bit is ignored.
    half_lane = offset[1] ? data_in[31:16] : data_in[15:0];

    data_out = data_in;
    case (funct3)
      LOAD_LB:  data_out = {{24{byte_lane[7]}}, byte_lane};
      LOAD_LBU: data_out = {24'd0, byte_lane};
      LOAD_LH:  data_out = {{16{half_lane[15]}}, half_lane};
      LOAD_LHU: data_out = {16'd0, half_lane};
      default:  data_out = data_in;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Merges ALU results and queued load returns onto the single register-file write port,
// with a busy mask for hazards and a stall request when the load queue is starved.
module writeback_unit
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_result,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [4:0]  load_rd,
  input  logic [2:0]  load_funct3,
  input  logic [1:0]  load_offset,
  input  logic [31:0] load_data,
  output logic        write,
  output logic [4:0]  c_address,
  output logic [31:0] c_in,
  output logic [31:0] busy_mask,
  output logic        alu_stall
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);

  wb_entry_t         mem_q [DEPTH];
  wb_entry_t         mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, idx;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              alu_stall_q, alu_stall_d;
  logic              write_q, write_d;
  logic [4:0]        c_address_q, c_address_d;
  logic [31:0]       c_in_q, c_in_d;
  logic [31:0]       ext_data;
  logic              fifo_empty, alu_sel, accept, load_keep, pop, bypass, push;

  load_extend u_load_extend (
    .funct3   (load_funct3),
    .offset   (load_offset),
    .data_in  (load_data),
    .data_out (ext_data)
  );

  // Readiness comes from the registered count only; a pop in the same cycle gives no credit.
  assign load_ready = reset && (count_q != CNT_W'(DEPTH));

  always_comb begin
    fifo_empty = (count_q == '0);
    alu_sel    = alu_valid && (alu_rd != 5'd0);
    accept     = load_valid && load_ready;
    load_keep  = accept && (load_rd != 5'd0);
    pop        = !alu_sel && !fifo_empty;
    bypass     = !alu_sel && fifo_empty && load_keep;
    push       = load_keep && !bypass;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = '{rd: load_rd, data: ext_data};
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    if (fifo_empty || pop) begin
      starve_d    = '0;
      alu_stall_d = 1'b0;
    end else begin
      starve_d    = (starve_q == SC_W'(STARVE_LIMIT)) ? starve_q : starve_q + SC_W'(1);
      alu_stall_d = (starve_d == SC_W'(STARVE_LIMIT)) ? 1'b1 : alu_stall_q;
    end

    write_d     = alu_sel || pop || bypass;
    c_address_d = c_address_q;
    c_in_d      = c_in_q;
    if (alu_sel) begin
      c_address_d = alu_rd;
      c_in_d      = alu_result;
    end else if (pop) begin
      c_address_d = mem_q[rd_ptr_q].rd;
      c_in_d      = mem_q[rd_ptr_q].data;
    end else if (bypass) begin
      c_address_d = load_rd;
      c_in_d      = ext_data;
    end
  end

  always_comb begin
    busy_mask = '0;
    idx       = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) busy_mask[mem_q[idx].rd] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      alu_stall_q <= 1'b0;
      write_q     <= 1'b0;
      c_address_q <= '0;
      c_in_q      <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      alu_stall_q <= alu_stall_d;
      write_q     <= write_d;
      c_address_q <= c_address_d;
      c_in_q      <= c_in_d;
    end
  end

  assign write     = write_q;
  assign c_address = c_address_q;
  assign c_in      = c_in_q;
  assign alu_stall = alu_stall_q;

  // An ALU write to a register with a queued load would overtake that load.
  a_no_alu_overtake : assert property (@(posedge clock) disable iff (!reset)
    !(alu_valid && alu_rd != 5'd0 && busy_mask[alu_rd]));

endmodule

// File: tb/tb_writeback_unit.sv
// Directed test of writeback_unit: ALU path, bypass extension, conflicts, full queue,
// starvation stall and mid-operation reset.
module tb_writeback_unit;
  import riscv_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        load_valid;
  logic        load_ready;
  logic [4:0]  load_rd;
  logic [2:0]  load_funct3;
  logic [1:0]  load_offset;
  logic [31:0] load_data;
  logic        write;
  logic [4:0]  c_address;
  logic [31:0] c_in;
  logic [31:0] busy_mask;
  logic        alu_stall;

  int n_checks = 0;
  int n_errors = 0;

  writeback_unit #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_result  (alu_result),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_rd     (load_rd),
    .load_funct3 (load_funct3),
    .load_offset (load_offset),
    .load_data   (load_data),
    .write       (write),
    .c_address   (c_address),
    .c_in        (c_in),
    .busy_mask   (busy_mask),
    .alu_stall   (alu_stall)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_result  = '0;
    load_valid  = 1'b0;
    load_rd     = '0;
    load_funct3 = '0;
    load_offset = '0;
    load_data   = '0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] res);
    alu_valid  = 1'b1;
    alu_rd     = rd;
    alu_result = res;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [2:0] f3,
                            input logic [1:0] off, input logic [31:0] data);
    load_valid  = 1'b1;
    load_rd     = rd;
    load_funct3 = f3;
    load_offset = off;
    load_data   = data;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] data;
    logic [31:0] exp;
  } ext_vec_t;

  ext_vec_t ext_vecs [8];

  initial begin
    ext_vecs[0] = '{LOAD_LB,  2'd2, 32'h0080_0000, 32'hFFFF_FF80};
    ext_vecs[1] = '{LOAD_LB,  2'd1, 32'h0000_7F00, 32'h0000_007F};
    ext_vecs[2] = '{LOAD_LBU, 2'd3, 32'hAB00_0000, 32'h0000_00AB};
    ext_vecs[3] = '{LOAD_LH,  2'd2, 32'h8001_1234, 32'hFFFF_8001};
    ext_vecs[4] = '{LOAD_LH,  2'd3, 32'h8001_1234, 32'hFFFF_8001};
    ext_vecs[5] = '{LOAD_LHU, 2'd0, 32'h0000_F00F, 32'h0000_F00F};
    ext_vecs[6] = '{LOAD_LW,  2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    ext_vecs[7] = '{3'b111,   2'd0, 32'h1357_9BDF, 32'h1357_9BDF};

    idle();
    reset = 1'b0;
    #12;
    check("rst_write", {31'd0, write}, 32'd0);
    check("rst_addr", {27'd0, c_address}, 32'd0);
    check("rst_cin", c_in, 32'd0);
    check("rst_busy", busy_mask, 32'd0);
    check("rst_ready", {31'd0, load_ready}, 32'd0);
    check("rst_stall", {31'd0, alu_stall}, 32'd0);
    step();
    reset = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, load_ready}, 32'd1);

    // ALU only, then idle holds address/data
    drive_alu(5'd5, 32'h1234_5678);
    step();
    check("alu_write", {31'd0, write}, 32'd1);
    check("alu_addr", {27'd0, c_address}, 32'd5);
    check("alu_cin", c_in, 32'h1234_5678);
    idle();
    step();
    check("idle_write", {31'd0, write}, 32'd0);
    check("idle_hold_addr", {27'd0, c_address}, 32'd5);
    check("idle_hold_cin", c_in, 32'h1234_5678);

    // Bypass path with extension table
    for (int i = 0; i < 8; i++) begin
      drive_load(5'd3, ext_vecs[i].f3, ext_vecs[i].off, ext_vecs[i].data);
      step();
      check($sformatf("byp%0d_write", i), {31'd0, write}, 32'd1);
      check($sformatf("byp%0d_addr", i), {27'd0, c_address}, 32'd3);
      check($sformatf("byp%0d_cin", i), c_in, ext_vecs[i].exp);
      check($sformatf("byp%0d_busy", i), busy_mask, 32'd0);
    end
    idle();
    step();

    // rd=0 dropped for both sources
    drive_alu(5'd0, 32'hFFFF_FFFF);
    step();
    check("alu_rd0_write", {31'd0, write}, 32'd0);
    idle();
    drive_load(5'd0, LOAD_LW, 2'd0, 32'h5555_5555);
    step();
    check("load_rd0_write", {31'd0, write}, 32'd0);
    check("load_rd0_busy", busy_mask, 32'd0);
    idle();

    // ALU and load collide: ALU first, load queued one cycle
    drive_alu(5'd7, 32'hA5A5_A5A5);
    drive_load(5'd9, LOAD_LHU, 2'd2, 32'hBEEF_0000);
    step();
    check("conf_addr0", {27'd0, c_address}, 32'd7);
    check("conf_cin0", c_in, 32'hA5A5_A5A5);
    check("conf_busy0", busy_mask, 32'h0000_0200);
    idle();
    step();
    check("conf_write1", {31'd0, write}, 32'd1);
    check("conf_addr1", {27'd0, c_address}, 32'd9);
    check("conf_cin1", c_in, 32'h0000_BEEF);
    check("conf_busy1", busy_mask, 32'd0);

    // Fill the queue while the ALU owns the port
    for (int i = 0; i <= 4; i++) begin
      drive_alu(5'd1, 32'h100 + i);
      drive_load(5'(10 + i), LOAD_LW, 2'd0, 32'h1000 + i);
      check($sformatf("fill%0d_ready", i), {31'd0, load_ready}, (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) step();
    end
    check("full_busy", busy_mask, 32'h0000_3C00);
    alu_valid = 1'b0;
    for (int j = 0; j <= 4; j++) begin
      logic taken;
      taken = load_valid && load_ready;
      step();
      if (taken) load_valid = 1'b0;
      check($sformatf("drain%0d_addr", j), {27'd0, c_address}, 32'(10 + j));
      check($sformatf("drain%0d_cin", j), c_in, 32'h1000 + j);
    end
    idle();
    check("drain_busy", busy_mask, 32'd0);
    check("drain_load_gone", {31'd0, load_valid}, 32'd0);
    step();

    // Starvation: one queued load, ALU valid every cycle
    drive_alu(5'd2, 32'h2222_0000);
    drive_load(5'd20, LOAD_LW, 2'd0, 32'hCAFE_F00D);
    step();
    load_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      alu_result = 32'h2222_0000 + k;
      step();
      check($sformatf("starve%0d_stall", k), {31'd0, alu_stall}, (k == 8) ? 32'd1 : 32'd0);
    end
    idle();
    step();
    check("starve_pop_addr", {27'd0, c_address}, 32'd20);
    check("starve_pop_cin", c_in, 32'hCAFE_F00D);
    check("starve_clear", {31'd0, alu_stall}, 32'd0);
    check("starve_busy", busy_mask, 32'd0);

    // Reset with three queued loads
    for (int i = 0; i < 3; i++) begin
      drive_alu(5'd3, 32'h3000 + i);
      drive_load(5'(21 + i), LOAD_LW, 2'd0, 32'h4000 + i);
      step();
    end
    check("pre_rst_busy", busy_mask, 32'h00E0_0000);
    idle();
    reset = 1'b0;
    #2;
    check("mid_rst_write", {31'd0, write}, 32'd0);
    check("mid_rst_busy", busy_mask, 32'd0);
    check("mid_rst_ready", {31'd0, load_ready}, 32'd0);
    check("mid_rst_cin", c_in, 32'd0);
    step();
    check("mid_rst_write2", {31'd0, write}, 32'd0);
    reset = 1'b1;
    #1;
    check("after_rst_ready", {31'd0, load_ready}, 32'd1);
    step();
    check("after_rst_write", {31'd0, write}, 32'd0);
    check("after_rst_busy", busy_mask, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
